flash_stream_writer: RTL and testbench
======================================

FLASH_STREAM_WRITER -- requirements
Module: flash_stream_writer

Interface
REQ-001 SHALL have parameter PAGE_BYTES, 256, page-program size in bytes.
REQ-002 SHALL have parameter SECTOR_BYTES, 65536, erase-sector size in bytes.
REQ-003 SHALL have parameter POLL_LIMIT, 1_000_000, maximum RDSR polls per wait before error.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request; latches start_addr and byte_count.
REQ-007 SHALL have port start_addr  in  24  first flash byte address.
REQ-008 SHALL have port byte_count  in  24  total bytes to write.
REQ-009 SHALL have ports s_data in 8, s_valid in 1, s_ready out 1  byte stream; a byte transfers when s_valid and s_ready are both high.
REQ-010 SHALL have ports mc_cmd out 8, mc_trigger out 1, mc_data_send out (3+256)*8  command, trigger and payload to qspi_mem_controller.
REQ-011 SHALL have ports mc_busy in 1, mc_readout in 8, mc_error in 1  controller status.
REQ-012 SHALL have ports busy out 1, done out 1, err out 1, cur_addr out 24  job status.

Function
REQ-013 SHALL implement states IDLE, FILL, WREN_E, ERASE, POLL_E, WREN_P, PROG, POLL_P, NEXT, DONE, ERR.
REQ-014 IDLE: start latches inputs, sets cur_addr=start_addr and remaining=byte_count; byte_count=0 -> DONE next cycle; otherwise -> FILL.
REQ-015 start outside IDLE, DONE or ERR SHALL be ignored.
REQ-016 FILL: chunk length = min(remaining, PAGE_BYTES - cur_addr[7:0]); s_ready high only in FILL, until chunk complete.
REQ-017 Byte k of the chunk SHALL be placed at payload offset k, MSB-first after the 24-bit address; unfilled payload bytes SHALL be 8'hFF.
REQ-018 Chunk complete -> WREN_E if first chunk of the job or cur_addr%SECTOR_BYTES==0; otherwise -> WREN_P.
REQ-019 Command issue: mc_trigger high exactly one cycle, only while mc_busy low; the next cycle waits; completion = mc_busy low with mc_trigger low.
REQ-020 WREN_E issues CMD_WREN -> ERASE issues CMD_SE with the sector-aligned address -> POLL_E.
REQ-021 WREN_P issues CMD_WREN -> PROG issues CMD_PP with address cur_addr -> POLL_P.
REQ-022 POLL_E/POLL_P: repeat CMD_RDSR; mc_readout[0]==0 -> leave (POLL_E -> WREN_P, POLL_P -> NEXT); poll count reaching POLL_LIMIT -> ERR.
REQ-023 NEXT: cur_addr += chunk length, modulo 2^24; remaining -= chunk length; remaining==0 -> DONE, else -> FILL.
REQ-024 mc_error high at any command completion -> ERR; no further commands issue.
REQ-025 busy high in every state except IDLE, DONE and ERR.
REQ-026 done and err are level outputs, held until the next accepted start; the start cycle clears them.
REQ-027 A stalled stream (s_valid low) SHALL hold FILL indefinitely, with no timeout.

Reset
REQ-028 When reset is low: state=IDLE; mc_trigger, s_ready, busy, done and err = 0; cur_addr=0; mc_cmd=0; mc_data_send all 1s.
REQ-029 Reset mid-operation SHALL abort immediately; the flash state afterward is undefined; no trigger is issued until a new start.

Structure
REQ-030 Command codes CMD_WREN, CMD_SE (8'hD8), CMD_RDSR (8'h05), CMD_PP and the WIP bit index SHALL live in shared defs.vh.
REQ-031 A command-issue/completion handshake sub-module, mc_cmd_issuer, is natural; all other logic stays in one FSM.

Verification
REQ-032 start_addr=24'h010000, byte_count=256, bytes 0..255 -> WREN, SE 010000, RDSR polling, WREN, PP 010000 carrying those bytes; done=1, cur_addr=24'h010100.
REQ-033 start_addr=24'h0000F0, byte_count=32 -> two PPs: 16 bytes at 0000F0, then 16 bytes at 000100 (second PP preceded by WREN only); payload tails 8'hFF.
REQ-034 Job crossing 24'h01FF00 -> 24'h020000 -> SE 020000 issued before the PP at 020000.
REQ-035 Model holds RDSR bit0=1 forever with POLL_LIMIT=8 -> exactly 8 RDSR commands, then err=1, busy=0.
REQ-036 byte_count=0 -> done=1 one cycle after start; no mc_trigger pulse.
REQ-037 reset low during PROG, then high -> all outputs at reset values; no trigger until the next start.

Source files
------------

// File: rtl/flash_stream_writer_pkg.sv
// Shared definitions for the flash stream writer: flash command codes,
// status-register bit positions and the FSM state encodings.
package flash_stream_writer_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_SE   = 8'hD8;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam int         WIP_BIT  = 0;
    localparam logic [7:0] WIP_MASK = 8'h01 << WIP_BIT;

    typedef enum logic [3:0] {
        IDLE, FILL, WREN_E, ERASE, POLL_E, WREN_P, PROG, POLL_P, NEXT, DONE, ERR
    } fsw_state_t;

    typedef enum logic [2:0] {
        ISS_IDLE, ISS_ARM, ISS_TRIG, ISS_GAP, ISS_WAIT
    } iss_state_t;

    // Command byte presented to the controller in each command-issuing state.
    function automatic logic [7:0] state_cmd(input fsw_state_t s);
        case (s)
            WREN_E, WREN_P: return CMD_WREN;
            ERASE:          return CMD_SE;
            PROG:           return CMD_PP;
            POLL_E, POLL_P: return CMD_RDSR;
            default:        return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/flash_stream_writer_mc_cmd_issuer.sv
// One-command handshake with the memory controller: wait for idle, pulse
// trigger for one cycle, skip a cycle, then report completion when busy drops.
module flash_stream_writer_mc_cmd_issuer
    import flash_stream_writer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic mc_busy,
    input  logic mc_error,
    output logic trigger,
    output logic cmd_done,
    output logic cmd_err
);

    iss_state_t state, state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ISS_IDLE;
        else        state <= state_next;
    end

    // A held request re-issues automatically, which is how status polling repeats.
    always_comb begin
        state_next = state;
        trigger    = 1'b0;
        cmd_done   = 1'b0;
        cmd_err    = 1'b0;
        case (state)
            ISS_IDLE: if (req) state_next = ISS_ARM;
            ISS_ARM:  if (!mc_busy) state_next = ISS_TRIG;
            ISS_TRIG: begin
                trigger    = 1'b1;
                state_next = ISS_GAP;
            end
            ISS_GAP:  state_next = ISS_WAIT;
            ISS_WAIT: if (!mc_busy) begin
                cmd_done   = 1'b1;
                cmd_err    = mc_error;
                state_next = ISS_IDLE;
            end
            default:  state_next = ISS_IDLE;
        endcase
    end

endmodule

// File: rtl/flash_stream_writer.sv
// Streams bytes into flash page by page, erasing each sector on first touch
// and polling the status register after every erase and program.
module flash_stream_writer
    import flash_stream_writer_pkg::*;
#(
    parameter int PAGE_BYTES   = 256,
    parameter int SECTOR_BYTES = 65536,
    parameter int POLL_LIMIT   = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [23:0]                   start_addr,
    input  logic [23:0]                   byte_count,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [7:0]                    mc_cmd,
    output logic                          mc_trigger,
    output logic [(3+PAGE_BYTES)*8-1:0]   mc_data_send,
    input  logic                          mc_busy,
    input  logic [7:0]                    mc_readout,
    input  logic                          mc_error,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [23:0]                   cur_addr
);

    localparam int          PW          = (3 + PAGE_BYTES) * 8;
    localparam logic [23:0] PAGE_MASK   = 24'(PAGE_BYTES - 1);
    localparam logic [23:0] SECTOR_MASK = 24'(SECTOR_BYTES - 1);

    fsw_state_t     state, state_next;
    logic [23:0]    remaining;
    logic [23:0]    fill_cnt;
    logic           first_chunk;
    logic [31:0]    poll_cnt;
    logic [PW-1:0]  payload;

    logic [23:0]    page_room;
    logic [23:0]    chunk_len;
    logic           s_fire;
    logic           sector_start;
    logic           wip;
    logic           cmd_req;
    logic           cmd_done;
    logic           cmd_err;

    assign page_room    = 24'(PAGE_BYTES) - (cur_addr & PAGE_MASK);
    assign chunk_len    = (remaining < page_room) ? remaining : page_room;
    assign s_ready      = (state == FILL);
    assign s_fire       = s_valid && s_ready;
    assign sector_start = ((cur_addr & SECTOR_MASK) == 24'd0);
    assign wip          = ((mc_readout & WIP_MASK) != 8'h00);
    assign cmd_req      = (state_cmd(state) != 8'h00);
    assign mc_cmd       = state_cmd(state);
    assign mc_data_send = payload;
    assign busy         = !(state == IDLE || state == DONE || state == ERR);
    assign done         = (state == DONE);
    assign err          = (state == ERR);

    flash_stream_writer_mc_cmd_issuer u_issuer (
        .clk      (clk),
        .reset    (reset),
        .req      (cmd_req),
        .mc_busy  (mc_busy),
        .mc_error (mc_error),
        .trigger  (mc_trigger),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = (byte_count == 24'd0) ? DONE : FILL;
            FILL: if (s_fire && (fill_cnt + 24'd1 == chunk_len))
                      state_next = (first_chunk || sector_start) ? WREN_E : WREN_P;
            WREN_E: if (cmd_done) state_next = cmd_err ? ERR : ERASE;
            ERASE:  if (cmd_done) state_next = cmd_err ? ERR : POLL_E;
            WREN_P: if (cmd_done) state_next = cmd_err ? ERR : PROG;
            PROG:   if (cmd_done) state_next = cmd_err ? ERR : POLL_P;
            POLL_E, POLL_P: if (cmd_done) begin
                if (cmd_err)
                    state_next = ERR;
                else if (!wip)
                    state_next = (state == POLL_E) ? WREN_P : NEXT;
                else if (poll_cnt + 32'd1 >= 32'(POLL_LIMIT))
                    state_next = ERR;
            end
            NEXT:    state_next = (remaining == chunk_len) ? DONE : FILL;
            default: state_next = IDLE;
        endcase
    end

    // The address field is rewritten just before ERASE/PROG so WREN and RDSR never care about it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cur_addr    <= 24'd0;
            remaining   <= 24'd0;
            fill_cnt    <= 24'd0;
            first_chunk <= 1'b0;
            poll_cnt    <= 32'd0;
            payload     <= '1;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    cur_addr    <= start_addr;
                    remaining   <= byte_count;
                    fill_cnt    <= 24'd0;
                    first_chunk <= 1'b1;
                    payload     <= '1;
                end
                FILL: if (s_fire) begin
                    for (int k = 0; k < PAGE_BYTES; k++)
                        if (fill_cnt == 24'(k)) payload[(PAGE_BYTES-1-k)*8 +: 8] <= s_data;
                    fill_cnt <= fill_cnt + 24'd1;
                end
                WREN_E: if (cmd_done) begin
                    payload[PW-1 -: 24] <= cur_addr & ~SECTOR_MASK;
                    poll_cnt            <= 32'd0;
                end
                WREN_P: if (cmd_done) begin
                    payload[PW-1 -: 24] <= cur_addr;
                    poll_cnt            <= 32'd0;
                end
                POLL_E, POLL_P: if (cmd_done) poll_cnt <= poll_cnt + 32'd1;
                NEXT: begin
                    cur_addr    <= cur_addr + chunk_len;
                    remaining   <= remaining - chunk_len;
                    fill_cnt    <= 24'd0;
                    first_chunk <= 1'b0;
                    payload     <= '1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_stream_writer.sv
// Directed bench for flash_stream_writer with a behavioural memory-controller
// model that logs every triggered command and its payload.
module tb_flash_stream_writer;

    localparam int PW = (3 + 256) * 8;

    // WREN, SE, RDSR x2, WREN, PP, RDSR x2 repeated for two sector-opening chunks
    localparam logic [7:0] SEQ_C [0:15] = '{8'h06, 8'hD8, 8'h05, 8'h05, 8'h06, 8'h02, 8'h05, 8'h05,
                                            8'h06, 8'hD8, 8'h05, 8'h05, 8'h06, 8'h02, 8'h05, 8'h05};
    localparam logic [7:0] SEQ_B [0:11] = '{8'h06, 8'hD8, 8'h05, 8'h05, 8'h06, 8'h02, 8'h05, 8'h05,
                                            8'h06, 8'h02, 8'h05, 8'h05};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [23:0]   start_addr = 24'd0;
    logic [23:0]   byte_count = 24'd0;
    logic [7:0]    s_data = 8'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    mc_cmd;
    logic          mc_trigger;
    logic [PW-1:0] mc_data_send;
    logic          mc_busy;
    logic [7:0]    mc_readout;
    logic          mc_error = 1'b0;
    logic          busy, done, err;
    logic [23:0]   cur_addr;

    int compared = 0;
    int mismatched = 0;
    int timeouts = 0;

    logic [7:0]    log_cmd [0:255];
    logic [PW-1:0] log_data [0:255];
    int            n_cmd = 0;
    int            trig_viol = 0;
    logic [1:0]    lat;
    logic          last_rdsr;
    logic          prev_trig;
    logic          wip_stuck = 1'b0;

    always #5 clk = ~clk;

    flash_stream_writer #(.PAGE_BYTES(256), .SECTOR_BYTES(65536), .POLL_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .byte_count(byte_count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mc_cmd(mc_cmd), .mc_trigger(mc_trigger), .mc_data_send(mc_data_send),
        .mc_busy(mc_busy), .mc_readout(mc_readout), .mc_error(mc_error),
        .busy(busy), .done(done), .err(err), .cur_addr(cur_addr)
    );

    // Controller model: busy for three cycles per command; the first RDSR after
    // any other command reports WIP=1, the next reports ready (unless stuck).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_busy    <= 1'b0;
            lat        <= 2'd0;
            mc_readout <= 8'h00;
            last_rdsr  <= 1'b0;
            prev_trig  <= 1'b0;
        end else begin
            prev_trig <= mc_trigger;
            if (mc_trigger && (mc_busy || prev_trig)) trig_viol <= trig_viol + 1;
            if (mc_busy) begin
                if (lat == 2'd0) mc_busy <= 1'b0;
                else             lat <= lat - 2'd1;
            end else if (mc_trigger) begin
                mc_busy <= 1'b1;
                lat     <= 2'd2;
                if (n_cmd < 256) begin
                    log_cmd[n_cmd]  <= mc_cmd;
                    log_data[n_cmd] <= mc_data_send;
                end
                n_cmd <= n_cmd + 1;
                if (mc_cmd == 8'h05) mc_readout <= {7'd0, wip_stuck | !last_rdsr};
                last_rdsr <= (mc_cmd == 8'h05);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pay(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            int bad;
            bad = 0;
            mismatched++;
            for (int b = 258; b >= 0; b--)
                if (obs[PW-1-8*b -: 8] !== exp[PW-1-8*b -: 8]) bad = b;
            $error("[TB] FAIL %s: payload byte %0d observed %02h expected %02h",
                   tag, bad, obs[PW-1-8*bad -: 8], exp[PW-1-8*bad -: 8]);
        end
    endtask

    function automatic logic [PW-1:0] make_pay(input logic [23:0] a, input logic [7:0] v0, input int len);
        logic [PW-1:0] p;
        logic [7:0]    v;
        p = '1;
        v = v0;
        p[PW-1 -: 24] = a;
        for (int k = 0; k < len; k++) begin
            p[PW-25-8*k -: 8] = v;
            v = v + 8'd1;
        end
        return p;
    endfunction

    function automatic logic [31:0] log_addr(input int idx);
        logic [PW-1:0] d;
        d = log_data[idx];
        return {8'd0, d[PW-1 -: 24]};
    endfunction

    task automatic start_job(input logic [23:0] a, input logic [23:0] n);
        start = 1'b1;
        start_addr = a;
        byte_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        int t;
        t = 0;
        s_data = v;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) timeouts++;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic push_stream(input logic [7:0] v0, input int n, input int stall_at);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                s_valid = 1'b0;
                repeat (50) @(negedge clk);
                check("stall_s_ready", {31'd0, s_ready}, 32'd1);
                check("stall_busy", {31'd0, busy}, 32'd1);
            end
            push_byte(v0 + 8'(i));
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) timeouts++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_trigger"}, {31'd0, mc_trigger}, 32'd0);
        check({tag, "_cur_addr"}, {8'd0, cur_addr}, 32'd0);
        check({tag, "_mc_cmd"}, {24'd0, mc_cmd}, 32'd0);
        check_pay({tag, "_data_send"}, mc_data_send, '1);
    endtask

    initial begin
        int base;
        int rdsr;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // One full page into a fresh sector, with a mid-stream stall
        base = n_cmd;
        start_job(24'h010000, 24'd256);
        push_stream(8'h00, 256, 100);
        wait_end();
        check("A_cmd_count", n_cmd - base, 32'd8);
        for (int i = 0; i < 8; i++) check("A_cmd_seq", {24'd0, log_cmd[base+i]}, {24'd0, SEQ_C[i]});
        check("A_se_addr", log_addr(base + 1), 32'h010000);
        check("A_pp_addr", log_addr(base + 5), 32'h010000);
        check_pay("A_pp_data", log_data[base + 5], make_pay(24'h010000, 8'h00, 256));
        check("A_done", {31'd0, done}, 32'd1);
        check("A_err", {31'd0, err}, 32'd0);
        check("A_busy", {31'd0, busy}, 32'd0);
        check("A_cur_addr", {8'd0, cur_addr}, 32'h010100);

        // Page-crossing job; a start pulse while busy must be ignored
        base = n_cmd;
        start_job(24'h0000F0, 24'd32);
        push_stream(8'hA0, 32, -1);
        start_job(24'h123456, 24'd0);
        wait_end();
        check("B_cmd_count", n_cmd - base, 32'd12);
        for (int i = 0; i < 12; i++) check("B_cmd_seq", {24'd0, log_cmd[base+i]}, {24'd0, SEQ_B[i]});
        check("B_se_addr", log_addr(base + 1), 32'h000000);
        check_pay("B_pp1_data", log_data[base + 5], make_pay(24'h0000F0, 8'hA0, 16));
        check_pay("B_pp2_data", log_data[base + 9], make_pay(24'h000100, 8'hB0, 16));
        check("B_done", {31'd0, done}, 32'd1);
        check("B_cur_addr", {8'd0, cur_addr}, 32'h000110);

        // Sector crossing: erase of 020000 precedes the program at 020000
        base = n_cmd;
        start_job(24'h01FF00, 24'd300);
        push_stream(8'h3C, 300, -1);
        wait_end();
        check("C_cmd_count", n_cmd - base, 32'd16);
        for (int i = 0; i < 16; i++) check("C_cmd_seq", {24'd0, log_cmd[base+i]}, {24'd0, SEQ_C[i]});
        check("C_se1_addr", log_addr(base + 1), 32'h010000);
        check_pay("C_pp1_data", log_data[base + 5], make_pay(24'h01FF00, 8'h3C, 256));
        check("C_se2_addr", log_addr(base + 9), 32'h020000);
        check_pay("C_pp2_data", log_data[base + 13], make_pay(24'h020000, 8'h3C, 44));
        check("C_done", {31'd0, done}, 32'd1);
        check("C_cur_addr", {8'd0, cur_addr}, 32'h02002C);

        // Flash never leaves WIP: exactly POLL_LIMIT polls, then error
        wip_stuck = 1'b1;
        base = n_cmd;
        start_job(24'h000000, 24'd1);
        push_stream(8'hAA, 1, -1);
        wait_end();
        rdsr = 0;
        for (int i = base; i < n_cmd && i < 256; i++) if (log_cmd[i] == 8'h05) rdsr++;
        check("D_rdsr_count", rdsr, 32'd8);
        check("D_cmd_count", n_cmd - base, 32'd10);
        check("D_err", {31'd0, err}, 32'd1);
        check("D_busy", {31'd0, busy}, 32'd0);
        check("D_done", {31'd0, done}, 32'd0);
        repeat (30) @(negedge clk);
        check("D_no_more_cmds", n_cmd - base, 32'd10);
        wip_stuck = 1'b0;

        // Zero-length job from the error state
        base = n_cmd;
        start_job(24'h000500, 24'd0);
        check("E_done", {31'd0, done}, 32'd1);
        check("E_err_cleared", {31'd0, err}, 32'd0);
        check("E_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("E_no_trigger", n_cmd - base, 32'd0);

        // Reset while in PROG aborts and stays quiet afterwards
        start_job(24'h000000, 24'd4);
        push_stream(8'h11, 4, -1);
        begin
            int t;
            t = 0;
            while (mc_cmd !== 8'h02 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) timeouts++;
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("F");
        @(negedge clk);
        reset = 1'b1;
        base = n_cmd;
        repeat (30) @(negedge clk);
        check("F_no_trigger", n_cmd - base, 32'd0);
        check("F_busy", {31'd0, busy}, 32'd0);

        check("trigger_protocol", trig_viol, 32'd0);
        check("wait_timeouts", timeouts, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
